// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall and forwarding control for the 5-stage MIPS pipeline,
//               driven by Tnew/Tuse codes and the HI/LO busy window.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse1,
  input  logic [1:0] d_tuse2,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_is_div,
  input  logic       d_uses_hilo,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       md_busy
);

  localparam int C_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES);
  localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES);
  localparam logic [1:0]         C_TUSE_NONE = 2'd3;

  logic [4:0]         r_dst_e, r_dst_m, r_dst_w;
  logic [1:0]         r_tnew_e, r_tnew_m, r_tnew_w;
  logic [4:0]         r_rs_e, r_rt_e;
  logic               r_md_e, r_md_div_e;
  logic [C_CNT_W-1:0] r_md_cnt;

  logic [1:0] w_rs_src, w_rt_src, w_rs_tnew, w_rt_tnew;
  logic [1:0] w_ers_src, w_ert_src, w_ers_tnew, w_ert_tnew;
  logic       w_rs_hz, w_rt_hz, w_md_hz;

  // Nearest producer of r: 0 none, 1 E, 2 M, 3 W. Register 0 never matches.
  function automatic logic [1:0] f_nearest(input logic [4:0] r, input logic [4:0] e,
                                           input logic [4:0] m, input logic [4:0] w);
    if (r == 5'd0)  return 2'd0;
    else if (r == e) return 2'd1;
    else if (r == m) return 2'd2;
    else if (r == w) return 2'd3;
    else             return 2'd0;
  endfunction

  function automatic logic [1:0] f_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  always_comb begin
    w_rs_src  = f_nearest(d_rs, r_dst_e, r_dst_m, r_dst_w);
    w_rt_src  = f_nearest(d_rt, r_dst_e, r_dst_m, r_dst_w);
    // Passing 0 as the E destination restricts E-stage operands to M/W.
    w_ers_src = f_nearest(r_rs_e, 5'd0, r_dst_m, r_dst_w);
    w_ert_src = f_nearest(r_rt_e, 5'd0, r_dst_m, r_dst_w);
  end

  always_comb begin
    w_rs_tnew = 2'd0;
    case (w_rs_src)
      2'd1: w_rs_tnew = r_tnew_e;
      2'd2: w_rs_tnew = r_tnew_m;
      2'd3: w_rs_tnew = r_tnew_w;
      default: w_rs_tnew = 2'd0;
    endcase
    w_rt_tnew = 2'd0;
    case (w_rt_src)
      2'd1: w_rt_tnew = r_tnew_e;
      2'd2: w_rt_tnew = r_tnew_m;
      2'd3: w_rt_tnew = r_tnew_w;
      default: w_rt_tnew = 2'd0;
    endcase
    w_ers_tnew = (w_ers_src == 2'd2) ? r_tnew_m : r_tnew_w;
    w_ert_tnew = (w_ert_src == 2'd2) ? r_tnew_m : r_tnew_w;
  end

  always_comb begin
    w_rs_hz  = (d_tuse1 != C_TUSE_NONE) && (w_rs_src != 2'd0) && (w_rs_tnew > d_tuse1);
    w_rt_hz  = (d_tuse2 != C_TUSE_NONE) && (w_rt_src != 2'd0) && (w_rt_tnew > d_tuse2);
    md_busy  = (r_md_cnt != '0) || r_md_e;
    w_md_hz  = d_uses_hilo && md_busy;
    stall    = w_rs_hz || w_rt_hz || w_md_hz;

    fwd_d_rs = ((d_tuse1 != C_TUSE_NONE) && (w_rs_src != 2'd0) && (w_rs_tnew == 2'd0))
               ? w_rs_src : 2'd0;
    fwd_d_rt = ((d_tuse2 != C_TUSE_NONE) && (w_rt_src != 2'd0) && (w_rt_tnew == 2'd0))
               ? w_rt_src : 2'd0;
    fwd_e_rs = ((w_ers_src != 2'd0) && (w_ers_tnew == 2'd0)) ? w_ers_src - 2'd1 : 2'd0;
    fwd_e_rt = ((w_ert_src != 2'd0) && (w_ert_tnew == 2'd0)) ? w_ert_src - 2'd1 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dst_e    <= 5'd0;
      r_dst_m    <= 5'd0;
      r_dst_w    <= 5'd0;
      r_tnew_e   <= 2'd0;
      r_tnew_m   <= 2'd0;
      r_tnew_w   <= 2'd0;
      r_rs_e     <= 5'd0;
      r_rt_e     <= 5'd0;
      r_md_e     <= 1'b0;
      r_md_div_e <= 1'b0;
      r_md_cnt   <= '0;
    end else begin
      r_dst_w  <= r_dst_m;
      r_tnew_w <= f_dec(r_tnew_m);
      r_dst_m  <= r_dst_e;
      r_tnew_m <= f_dec(r_tnew_e);
      if (stall) begin
        r_dst_e    <= 5'd0;
        r_tnew_e   <= 2'd0;
        r_rs_e     <= 5'd0;
        r_rt_e     <= 5'd0;
        r_md_e     <= 1'b0;
        r_md_div_e <= 1'b0;
      end else begin
        r_dst_e    <= d_dst;
        r_tnew_e   <= d_tnew;
        r_rs_e     <= d_rs;
        r_rt_e     <= d_rt;
        r_md_e     <= d_md_start;
        r_md_div_e <= d_md_start && d_md_is_div;
      end
      // The counter starts the edge after the md op reaches E; E itself covers the first busy cycle.
      if (r_md_e)
        r_md_cnt <= r_md_div_e ? C_DIV_LOAD : C_MULT_LOAD;
      else if (r_md_cnt != '0)
        r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed and random checks of hazard_ctrl against a
//               pipeline-occupancy reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse1, d_tuse2, d_tnew;
  logic       d_md_start, d_md_is_div, d_uses_hilo;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_tuse1(d_tuse1),
    .d_tuse2(d_tuse2), .d_dst(d_dst), .d_tnew(d_tnew), .d_md_start(d_md_start),
    .d_md_is_div(d_md_is_div), .d_uses_hilo(d_uses_hilo), .stall(stall),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
    .fwd_e_rt(fwd_e_rt), .md_busy(md_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: slot 0 = E, 1 = M, 2 = W.
  typedef struct {
    int dst;
    int tnew;
    int rs;
    int rt;
  } slot_t;

  slot_t pipe[3];
  int    cyc;
  bit    md_valid;
  int    md_t, md_len;
  int    m_stall, m_fdrs, m_fdrt, m_fers, m_fert, m_busy;
  int    cap_d_rs, cap_d_rt;

  function automatic int nearest(input int r);
    if (r == 0) return -1;
    for (int s = 0; s < 3; s++) if (pipe[s].dst == r) return s;
    return -1;
  endfunction

  function automatic int e_src(input int r);
    if (r == 0) return 0;
    for (int s = 1; s < 3; s++)
      if (pipe[s].dst == r) return (pipe[s].tnew == 0) ? s : 0;
    return 0;
  endfunction

  task automatic operand(input int r, input int tuse, output int hz, output int fwd);
    int s;
    s = nearest(r);
    hz = 0;
    fwd = 0;
    if (tuse != 3 && s >= 0) begin
      if (pipe[s].tnew > tuse) hz = 1;
      else if (pipe[s].tnew == 0) fwd = s + 1;
    end
  endtask

  task automatic model_eval();
    int h1, h2;
    operand(int'(d_rs), int'(d_tuse1), h1, m_fdrs);
    operand(int'(d_rt), int'(d_tuse2), h2, m_fdrt);
    m_fers  = e_src(pipe[0].rs);
    m_fert  = e_src(pipe[0].rt);
    m_busy  = (md_valid && cyc >= md_t && (cyc - md_t) <= md_len) ? 1 : 0;
    m_stall = (h1 != 0 || h2 != 0 || (d_uses_hilo && m_busy != 0)) ? 1 : 0;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
    md_valid = 0;
  endtask

  task automatic model_adv();
    if (reset) begin
      model_clear();
    end else begin
      pipe[2] = pipe[1];
      pipe[2].tnew = (pipe[1].tnew > 0) ? pipe[1].tnew - 1 : 0;
      pipe[1] = pipe[0];
      pipe[1].tnew = (pipe[0].tnew > 0) ? pipe[0].tnew - 1 : 0;
      if (m_stall != 0) pipe[0] = '{0, 0, 0, 0};
      else pipe[0] = '{int'(d_dst), int'(d_tnew), int'(d_rs), int'(d_rt)};
      if (m_stall == 0 && d_md_start) begin
        md_valid = 1;
        md_t     = cyc + 1;
        md_len   = d_md_is_div ? DIV_CYCLES : MULT_CYCLES;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    check("stall", stall, m_stall);
    check("fwd_d_rs", fwd_d_rs, m_fdrs);
    check("fwd_d_rt", fwd_d_rt, m_fdrt);
    check("fwd_e_rs", fwd_e_rs, m_fers);
    check("fwd_e_rt", fwd_e_rt, m_fert);
    check("md_busy", md_busy, m_busy);
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic set_d(input int rs, input int rt, input int tu1, input int tu2,
                       input int dst, input int tnew, input bit md, input bit dv, input bit hilo);
    d_rs = 5'(rs); d_rt = 5'(rt); d_tuse1 = 2'(tu1); d_tuse2 = 2'(tu2);
    d_dst = 5'(dst); d_tnew = 2'(tnew);
    d_md_start = md; d_md_is_div = dv; d_uses_hilo = hilo;
  endtask

  task automatic nop();
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  // Holds the D instruction until it issues; returns the stall-cycle count.
  task automatic issue(output int n);
    bit done;
    done = 0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      model_eval();
      check("iss_stall", stall, m_stall);
      check("iss_fwd_d_rs", fwd_d_rs, m_fdrs);
      check("iss_fwd_d_rt", fwd_d_rt, m_fdrt);
      check("iss_md_busy", md_busy, m_busy);
      if (stall === 1'b0) begin
        done = 1;
        cap_d_rs = int'(fwd_d_rs);
        cap_d_rt = int'(fwd_d_rt);
      end else begin
        n++;
      end
      @(posedge clk);
      model_adv();
      #1;
      if (!done && n > 40) begin
        check("issue_timeout", n, 0);
        done = 1;
      end
    end
  endtask

  task automatic drain();
    nop();
    repeat (4) cycle();
  endtask

  initial begin
    int n;
    cyc = 0;
    model_clear();
    reset = 1'b1;
    nop();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_stall", stall, 0);
    check("rst_fwd_d_rs", fwd_d_rs, 0);
    check("rst_fwd_d_rt", fwd_d_rt, 0);
    check("rst_fwd_e_rs", fwd_e_rs, 0);
    check("rst_fwd_e_rt", fwd_e_rt, 0);
    check("rst_md_busy", md_busy, 0);
    cycle();

    // lw $1 -> addu $3,$1,$2
    set_d(0, 0, 3, 3, 1, 2, 0, 0, 0); issue(n);
    set_d(1, 2, 1, 1, 3, 1, 0, 0, 0); issue(n);
    check("lu_stalls", n, 1);
    nop();
    check("lu_fwd_e_rs", fwd_e_rs, 2);
    drain();

    // lw $1 -> beq $1,$2
    set_d(0, 0, 3, 3, 1, 2, 0, 0, 0); issue(n);
    set_d(1, 2, 0, 0, 0, 0, 0, 0, 0); issue(n);
    check("lb_stalls", n, 2);
    check("lb_fwd_d_rs", cap_d_rs, 3);
    drain();

    // addu $1 -> beq $1,$0
    set_d(2, 3, 1, 1, 1, 1, 0, 0, 0); issue(n);
    set_d(1, 0, 0, 0, 0, 0, 0, 0, 0); issue(n);
    check("ab_stalls", n, 1);
    check("ab_fwd_d_rs", cap_d_rs, 2);
    check("ab_fwd_d_rt", cap_d_rt, 0);
    drain();

    // Writer to $0 never creates a dependency
    set_d(0, 0, 3, 3, 0, 2, 0, 0, 0); issue(n);
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); issue(n);
    check("z_stalls", n, 0);
    check("z_fwd_d_rs", cap_d_rs, 0);
    check("z_fwd_d_rt", cap_d_rt, 0);
    drain();

    // mult -> mflo
    set_d(1, 2, 1, 1, 0, 0, 1, 0, 1); issue(n);
    set_d(0, 0, 3, 3, 4, 1, 0, 0, 1);
    check("mult_busy_e", md_busy, 1);
    issue(n);
    check("mflo_stalls", n, MULT_CYCLES + 1);
    drain();

    // divu -> mfhi
    set_d(1, 2, 1, 1, 0, 0, 1, 1, 1); issue(n);
    set_d(0, 0, 3, 3, 4, 1, 0, 0, 1); issue(n);
    check("mfhi_stalls", n, DIV_CYCLES + 1);
    drain();

    // Reset during a load-use stall, with an md op in flight
    set_d(1, 2, 1, 1, 0, 0, 1, 0, 1); issue(n);
    set_d(0, 0, 3, 3, 1, 2, 0, 0, 0); issue(n);
    set_d(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rr_stall", stall, 0);
    check("rr_fwd_d_rs", fwd_d_rs, 0);
    check("rr_fwd_d_rt", fwd_d_rt, 0);
    check("rr_fwd_e_rs", fwd_e_rs, 0);
    check("rr_fwd_e_rt", fwd_e_rt, 0);
    check("rr_md_busy", md_busy, 0);
    drain();

    // Random traffic over a small register set to provoke frequent hazards
    for (int i = 0; i < 3000; i++) begin
      bit md;
      md = ($urandom_range(0, 15) == 0);
      set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            md, 1'($urandom_range(0, 1)), md || ($urandom_range(0, 7) == 0));
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
